// File: rtl/dm_sba_regs_pkg.sv
// Shared types and constants for the debug-module system-bus-access register bank.
// Holds the sbcs layout, DM register addresses and sberror codes.
package dm_sba_regs_pkg;

    localparam logic [6:0] SBCS       = 7'h38;
    localparam logic [6:0] SBAddress0 = 7'h39;
    localparam logic [6:0] SBAddress1 = 7'h3A;
    localparam logic [6:0] SBData0    = 7'h3C;
    localparam logic [6:0] SBData1    = 7'h3D;

    typedef enum logic [2:0] {
        SBERR_NONE  = 3'd0,
        SBERR_ALIGN = 3'd3,
        SBERR_SIZE  = 3'd4
    } sberror_e;

    typedef struct packed {
        logic [2:0] sbversion;
        logic [5:0] zero0;
        logic       sbbusyerror;
        logic       sbbusy;
        logic       sbreadonaddr;
        logic [2:0] sbaccess;
        logic       sbautoincrement;
        logic       sbreadondata;
        logic [2:0] sberror;
        logic [6:0] sbasize;
        logic [4:0] sbaccess_support;
    } sbcs_t;

    // Byte/half/word always; doubleword only on a 64-bit bus.
    function automatic logic [4:0] access_support(input int bus_width);
        return (bus_width == 64) ? 5'b01111 : 5'b00111;
    endfunction

endpackage

// File: rtl/dm_sba_regs.sv
// SBA CSR bank: decodes DM register accesses, holds sbcs/sbaddress/sbdata and
// issues single-cycle trigger pulses to the SBA bus master.
module dm_sba_regs
    import dm_sba_regs_pkg::*;
#(
    parameter int BusWidth = 32
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                dmactive_i,
    input  logic                reg_we_i,
    input  logic                reg_re_i,
    input  logic [6:0]          reg_addr_i,
    input  logic [31:0]         reg_wdata_i,
    output logic [31:0]         reg_rdata_o,
    output logic                reg_rvalid_o,
    output logic [BusWidth-1:0] sbaddress_o,
    output logic                sbaddress_write_valid_o,
    output logic                sbreadonaddr_o,
    output logic                sbautoincrement_o,
    output logic [2:0]          sbaccess_o,
    output logic                sbreadondata_o,
    output logic [BusWidth-1:0] sbdata_o,
    output logic                sbdata_read_valid_o,
    output logic                sbdata_write_valid_o,
    input  logic [BusWidth-1:0] sbaddress_i,
    input  logic [BusWidth-1:0] sbdata_i,
    input  logic                sbdata_valid_i,
    input  logic                sbbusy_i,
    input  logic                sberror_valid_i,
    input  logic [2:0]          sberror_i
);

    localparam bit Is64 = (BusWidth == 64);

    sbcs_t       sbcs_q;
    sbcs_t       sbcs_view;
    logic [63:0] addr_q;
    logic [63:0] data_q;
    logic        read_pending_q;
    logic        access_pending_q;

    logic        clear;
    logic        rd;
    logic        hit_sbcs, hit_a0, hit_a1, hit_d0, hit_d1;
    logic        ok;
    logic        busy_viol;
    logic        trig_addr, trig_dwr, trig_drd;
    logic [31:0] rdata_mux;

    always_comb begin
        clear     = rst_i || !dmactive_i;
        // A simultaneous read is dropped entirely: it returns 0 and has no side effects.
        rd        = reg_re_i && !reg_we_i;
        hit_sbcs  = (reg_addr_i == SBCS);
        hit_a0    = (reg_addr_i == SBAddress0);
        hit_a1    = (reg_addr_i == SBAddress1) && Is64;
        hit_d0    = (reg_addr_i == SBData0);
        hit_d1    = (reg_addr_i == SBData1) && Is64;
        ok        = !sbcs_q.sbbusyerror && (sbcs_q.sberror == SBERR_NONE);
        busy_viol = sbbusy_i && ((reg_we_i && (hit_a0 || hit_a1 || hit_d0 || hit_d1))
                                 || (rd && hit_d0));
        trig_addr = reg_we_i && hit_a0 && !sbbusy_i && ok;
        trig_dwr  = reg_we_i && hit_d0 && !sbbusy_i && ok;
        trig_drd  = rd && hit_d0 && !sbbusy_i && ok && sbcs_q.sbreadondata;

        sbcs_view                  = sbcs_q;
        sbcs_view.sbversion        = 3'd1;
        sbcs_view.zero0            = '0;
        sbcs_view.sbbusy           = sbbusy_i;
        sbcs_view.sbasize          = 7'(BusWidth);
        sbcs_view.sbaccess_support = access_support(BusWidth);

        rdata_mux = '0;
        if (hit_sbcs)    rdata_mux = sbcs_view;
        else if (hit_a0) rdata_mux = addr_q[31:0];
        else if (hit_a1) rdata_mux = addr_q[63:32];
        else if (hit_d0) rdata_mux = data_q[31:0];
        else if (hit_d1) rdata_mux = data_q[63:32];
    end

    always_ff @(posedge clk_i) begin
        if (clear) begin
            sbcs_q                  <= '0;
            sbcs_q.sbaccess         <= 3'd2;
            addr_q                  <= '0;
            data_q                  <= '0;
            read_pending_q          <= 1'b0;
            access_pending_q        <= 1'b0;
            reg_rdata_o             <= '0;
            reg_rvalid_o            <= 1'b0;
            sbaddress_write_valid_o <= 1'b0;
            sbdata_write_valid_o    <= 1'b0;
            sbdata_read_valid_o     <= 1'b0;
        end else begin
            // NOTE: non-blocking throughout, so later assignments in this block
            // (hardware error sets) take priority over earlier ones (W1C clears).
            sbaddress_write_valid_o <= trig_addr;
            sbdata_write_valid_o    <= trig_dwr;
            sbdata_read_valid_o     <= trig_drd;
            reg_rvalid_o            <= reg_re_i;
            reg_rdata_o             <= rd ? rdata_mux : 32'h0;

            // Completions are only honoured while an access this bank triggered is outstanding.
            if (sbdata_valid_i && access_pending_q) begin
                addr_q <= 64'(sbaddress_i);
                if (read_pending_q) data_q <= 64'(sbdata_i);
            end

            if ((trig_addr && sbcs_q.sbreadonaddr) || trig_drd) read_pending_q <= 1'b1;
            else if (sbdata_valid_i || sberror_valid_i)         read_pending_q <= 1'b0;

            if (trig_addr || trig_dwr || trig_drd)        access_pending_q <= 1'b1;
            else if (sbdata_valid_i || sberror_valid_i)   access_pending_q <= 1'b0;

            if (reg_we_i && hit_sbcs) begin
                sbcs_q.sbbusyerror     <= sbcs_q.sbbusyerror & ~reg_wdata_i[22];
                sbcs_q.sbreadonaddr    <= reg_wdata_i[20];
                sbcs_q.sbaccess        <= reg_wdata_i[19:17];
                sbcs_q.sbautoincrement <= reg_wdata_i[16];
                sbcs_q.sbreadondata    <= reg_wdata_i[15];
                sbcs_q.sberror         <= sbcs_q.sberror & ~reg_wdata_i[14:12];
            end

            if (reg_we_i && !sbbusy_i) begin
                if (hit_a0) addr_q[31:0]  <= reg_wdata_i;
                if (hit_a1) addr_q[63:32] <= reg_wdata_i;
                if (hit_d0) data_q[31:0]  <= reg_wdata_i;
                if (hit_d1) data_q[63:32] <= reg_wdata_i;
            end

            if (busy_viol)       sbcs_q.sbbusyerror <= 1'b1;
            if (sberror_valid_i) sbcs_q.sberror     <= sberror_i;
        end
    end

    assign sbaddress_o       = addr_q[BusWidth-1:0];
    assign sbdata_o          = data_q[BusWidth-1:0];
    assign sbreadonaddr_o    = sbcs_q.sbreadonaddr;
    assign sbautoincrement_o = sbcs_q.sbautoincrement;
    assign sbaccess_o        = sbcs_q.sbaccess;
    assign sbreadondata_o    = sbcs_q.sbreadondata;

endmodule

// File: doc/dm_sba_regs.md
Name: dm_sba_regs

Overview:
Debug-module register bank for the system-bus-access (SBA) CSRs: sbcs, sbaddress0/1 and sbdata0/1. It decodes debugger register reads and writes, holds the SBA control, address and data state, and issues the single-cycle trigger pulses that start accesses in the downstream SBA bus master. It captures the master's read data, post-increment address and error reports back into its registers. It sits between the DMI register decode and the SBA bus master.

Parameters:
BusWidth, 32, system-bus address/data width; legal values are 32 and 64.

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
dmactive_i  in  1  low = synchronous clear of all state to reset values
reg_we_i  in  1  register write strobe, one cycle
reg_re_i  in  1  register read strobe, one cycle
reg_addr_i  in  7  DM register address
reg_wdata_i  in  32  write data
reg_rdata_o  out  32  read data, registered
reg_rvalid_o  out  1  read data valid
sbaddress_o  out  BusWidth  current sbaddress
sbaddress_write_valid_o  out  1  pulse: sbaddress0 was written
sbreadonaddr_o  out  1  sbcs.sbreadonaddr
sbautoincrement_o  out  1  sbcs.sbautoincrement
sbaccess_o  out  3  sbcs.sbaccess
sbreadondata_o  out  1  sbcs.sbreadondata
sbdata_o  out  BusWidth  current sbdata
sbdata_read_valid_o  out  1  pulse: sbdata0 was read
sbdata_write_valid_o  out  1  pulse: sbdata0 was written
sbaddress_i  in  BusWidth  post-access (incremented) address from the master
sbdata_i  in  BusWidth  read data from the master
sbdata_valid_i  in  1  access complete
sbbusy_i  in  1  master busy
sberror_valid_i  in  1  master error report
sberror_i  in  3  master error code

Behaviour:
- Reset: synchronous, active-high on rst_i; dmactive_i=0 has the same effect. After reset all registers are 0, sbaccess=3'd2, all outputs are 0 except sbaccess_o=2, and no pulses are issued.
- Register map:
  - 0x38 sbcs: [31:29] sbversion=1 (RO); [22] sbbusyerror (W1C); [21] sbbusy = sbbusy_i (RO); [20] sbreadonaddr; [19:17] sbaccess; [16] sbautoincrement; [15] sbreadondata; [14:12] sberror (W1C); [11:5] sbasize = BusWidth (RO); [4:0] access support = 5'b00111 for BusWidth 32, 5'b01111 for BusWidth 64 (RO).
  - 0x39 sbaddress0, 0x3A sbaddress1, 0x3C sbdata0, 0x3D sbdata1.
  - sbaddress1 and sbdata1 exist only when BusWidth=64; otherwise they read 0 and ignore writes. Unmapped addresses read 0.
- Read response: reg_rdata_o and reg_rvalid_o are valid in the cycle after reg_re_i (latency 1). If reg_we_i and reg_re_i are asserted together, the write takes effect and the read returns 0.
- Error gate: `ok = !sbbusyerror && sberror==0`.
- Busy violation: any of the following while sbbusy_i=1 sets sbbusyerror, leaves register contents unchanged and issues no pulse:
  - a write to sbaddress0, sbaddress1, sbdata0 or sbdata1;
  - a read of sbdata0.
  Such a read still returns the stale sbdata0 value.
- sbaddress0 write with !sbbusy_i: sbaddress[31:0] is updated. If `ok`, sbaddress_write_valid_o pulses in the next cycle, aligned with the new sbaddress_o. If not `ok`, no pulse is issued.
- sbdata0 write with !sbbusy_i: sbdata[31:0] is updated. If `ok`, sbdata_write_valid_o pulses in the next cycle.
- sbdata0 read with !sbbusy_i: returns the current value. If `ok` and sbreadondata=1, sbdata_read_valid_o pulses in the next cycle.
- sbaddress1 and sbdata1 writes update bits [63:32] only and never issue a pulse.
- Read tracking: a read_pending flag is set on an sbaddress_write_valid_o pulse when sbreadonaddr=1, and on any sbdata_read_valid_o pulse. It is cleared on sbdata_valid_i or sberror_valid_i.
- Access completion (sbdata_valid_i):
  - sbaddress <= sbaddress_i.
  - If read_pending, sbdata <= sbdata_i.
  - Write completions do not modify sbdata.
- Master error (sberror_valid_i): sberror <= sberror_i.
- Simultaneous events:
  - A hardware set of sberror or sbbusyerror beats a same-cycle W1C clear.
  - A W1C write of 1 to sbbusyerror or sberror clears only those fields; other sbcs fields take the new write data.
- Pulses are single-cycle and never overlap; at most one trigger pulse is issued per register access.
- dmactive_i deasserted mid-access: all state clears, read_pending is dropped, and a later sbdata_valid_i is ignored until a new trigger is issued.

Decomposition:
- The dm package holds:
  - the sbcs_t packed struct;
  - DM address constants SBCS, SBAddress0, SBAddress1, SBData0, SBData1;
  - the sberror codes (0 none, 3 alignment, 4 size).
- Single module, no sub-module; the flat register-plus-pulse logic does not split naturally.

Test Plan:
1. Reset then read 0x38 (BusWidth=32) -> reg_rdata_o=0x20040407 one cycle later, with reg_rvalid_o=1.
2. Write sbcs=0x00140000 (readonaddr=1, sbaccess=2), then write 0x39=0x1000 -> sbaddress_o=0x1000 with sbaddress_write_valid_o pulsing for 1 cycle. Then drive sbdata_valid_i with sbdata_i=0xDEADBEEF and sbaddress_i=0x1004 -> read 0x3C returns 0xDEADBEEF and sbaddress_o=0x1004.
3. With sbbusy_i=1, write 0x3C=0x55 -> no pulse, sbdata unchanged, sbcs bit22=1. A subsequent 0x39 write after busy drops issues no pulse. Writing sbcs with bit22=1 clears bit22.
4. sberror_valid_i=1 with sberror_i=3 -> sbcs[14:12]=3 and sbdata0 writes issue no pulse. A W1C write of 0x7000 in the same cycle as a new sberror_valid_i (code 4) -> sberror=4.
5. With sbreadondata=1, read 0x3C -> old value returned and sbdata_read_valid_o pulses once. With sbreadondata=0 -> no pulse.
6. With BusWidth=64, write 0x3A=0x1 and 0x39=0x8 -> sbaddress_o=0x1_00000008 and exactly one pulse (on the 0x39 write). Deassert dmactive_i mid-access -> all registers are 0 next cycle, and a late sbdata_valid_i does not update sbdata.
